// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Steps a four-phase traffic intersection using an external interval timer
// as the time base. For each phase it latches that phase's duration, writes
// the 32-bit period to the timer (low half, then high half), and starts the
// timer in one-shot mode with its interrupt enabled. It then waits for the
// timeout interrupt, clears the timer status and moves on to the next phase.
// Dropping enable stops the timer, clears its status and parks the
// intersection in all-red.
//
// Optional feature: define TPS_PED_REQUEST_EN to add a pedestrian request.
// A request latched while running inserts an all-red walk phase (phase 4,
// timed by dur_walk) after phase 3.
//
// Parameters
//   TICK_MIN        period written to the timer when a duration is zero
//
// Ports
//   clk             system clock, all state on the rising edge
//   reset_n         asynchronous active-low reset
//   enable          1 runs the phase cycle, 0 stops it (all red)
//   dur_0..dur_3    phase durations in timer periods (timer runs value+1 clks)
//   tmr_address     timer register: 0 status, 1 control, 2 period_l, 3 period_h
//   tmr_chipselect  timer bus select
//   tmr_write_n     timer bus write strobe, active low
//   tmr_writedata   timer bus write data
//   tmr_irq         timer timeout interrupt (level, cleared by status write)
//   phase           current phase index
//   lights          {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
//   phase_start     one-cycle pulse when a new phase's lights take effect
//   busy            high whenever the sequencer is not idle
//   ped_req         (TPS_PED_REQUEST_EN) pedestrian request
//   dur_walk        (TPS_PED_REQUEST_EN) walk phase duration
//   walk            (TPS_PED_REQUEST_EN) walk signal, high during phase 4
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter logic [31:0] TICK_MIN = 32'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] dur_0,
  input  logic [31:0] dur_1,
  input  logic [31:0] dur_2,
  input  logic [31:0] dur_3,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq,
  output logic [2:0]  phase,
  output logic [5:0]  lights,
  output logic        phase_start,
  output logic        busy
`ifdef TPS_PED_REQUEST_EN
  ,
  input  logic        ped_req,
  input  logic [31:0] dur_walk,
  output logic        walk
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_PL    = 4'd1,
    ST_WR_PH    = 4'd2,
    ST_WR_CTRL  = 4'd3,
    ST_WAIT_IRQ = 4'd4,
    ST_CLR_ST   = 4'd5,
    ST_NEXT     = 4'd6,
    ST_STOP     = 4'd7,
    ST_STOP_CLR = 4'd8
  } state_t;

  localparam logic [2:0]  ADDR_STATUS    = 3'd0;
  localparam logic [2:0]  ADDR_CTRL      = 3'd1;
  localparam logic [2:0]  ADDR_PERIOD_L  = 3'd2;
  localparam logic [2:0]  ADDR_PERIOD_H  = 3'd3;
  localparam logic [15:0] CTRL_START_ITO = 16'h0005;
  localparam logic [15:0] CTRL_STOP      = 16'h0008;
  localparam logic [15:0] STATUS_CLEAR   = 16'h0000;
  localparam logic [2:0]  PHASE_FIRST    = 3'd0;
  localparam logic [2:0]  PHASE_LAST     = 3'd3;
  localparam logic [2:0]  PHASE_WALK     = 3'd4;
  localparam logic [5:0]  LIGHTS_ALL_RED = 6'b100100;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [31:0] dur_lat_q, dur_lat_d;
  logic [5:0]  lights_q, lights_d;
  logic        phase_start_q, phase_start_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        wr_n_q, wr_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic [2:0]  phase_adv_s;
  logic [2:0]  phase_tgt_s;
  logic [31:0] dur_sel_s;
  logic [31:0] dur_fix_s;
  logic        ped_go_s;

  // Light pattern shown for a given phase; anything else is all red.
  function automatic logic [5:0] lights_for(input logic [2:0] p);
    logic [5:0] l;
    case (p)
      3'd0:    l = 6'b001100;  // NS green, EW red
      3'd1:    l = 6'b010100;  // NS yellow, EW red
      3'd2:    l = 6'b100001;  // NS red, EW green
      3'd3:    l = 6'b100010;  // NS red, EW yellow
      default: l = LIGHTS_ALL_RED;
    endcase
    return l;
  endfunction

`ifdef TPS_PED_REQUEST_EN
  logic pending_q, pending_d;
  logic walk_q, walk_d;
  logic pend_take_s;

  // Sticky pedestrian request; consumed when NEXT leaves phase 3 for the walk
  // phase. A new request in that same cycle wins so it is not lost.
  always_comb begin
    pend_take_s = (state_q == ST_NEXT) && enable && (phase_q == PHASE_LAST) && pending_q;
    if (ped_req && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else if (pend_take_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Walk output follows the phase being started; forced low when stopping.
  always_comb begin
    if (state_d == ST_WR_PL) begin
      walk_d = (phase_d == PHASE_WALK);
    end else if (state_d == ST_STOP) begin
      walk_d = 1'b0;
    end else begin
      walk_d = walk_q;
    end
  end

  // Pedestrian request and walk registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      walk_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      walk_q    <= walk_d;
    end
  end

  assign ped_go_s = pending_q;
  assign walk     = walk_q;
`else
  assign ped_go_s = 1'b0;
`endif

  // Phase that follows the current one; phase 3 diverts to the walk phase
  // only when a pedestrian request is pending.
  always_comb begin
    case (phase_q)
      3'd0:    phase_adv_s = 3'd1;
      3'd1:    phase_adv_s = 3'd2;
      3'd2:    phase_adv_s = 3'd3;
      3'd3:    phase_adv_s = ped_go_s ? PHASE_WALK : PHASE_FIRST;
      default: phase_adv_s = PHASE_FIRST;
    endcase
  end

  // Duration of the phase about to start: WR_PL is only entered from IDLE
  // (always phase 0) or from NEXT (the advanced phase).
  always_comb begin
    if (state_q == ST_IDLE) begin
      phase_tgt_s = PHASE_FIRST;
    end else begin
      phase_tgt_s = phase_adv_s;
    end
    case (phase_tgt_s)
      3'd0:    dur_sel_s = dur_0;
      3'd1:    dur_sel_s = dur_1;
      3'd2:    dur_sel_s = dur_2;
      3'd3:    dur_sel_s = dur_3;
`ifdef TPS_PED_REQUEST_EN
      3'd4:    dur_sel_s = dur_walk;
`endif
      default: dur_sel_s = dur_0;
    endcase
    if (dur_sel_s == 32'd0) begin
      dur_fix_s = TICK_MIN;
    end else begin
      dur_fix_s = dur_sel_s;
    end
  end

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dur_lat_d = dur_lat_q;
    lights_d  = lights_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WR_PL;
          phase_d = phase_tgt_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_PL: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_WR_PH;
        end
      end
      ST_WR_PH: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_WR_CTRL;
        end
      end
      ST_WR_CTRL: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_WAIT_IRQ;
        end
      end
      ST_WAIT_IRQ: begin
        // Disable takes priority over a simultaneous timeout; STOP_CLR
        // clears the pending interrupt either way.
        if (!enable) begin
          state_d = ST_STOP;
        end else if (tmr_irq) begin
          state_d = ST_CLR_ST;
        end else begin
          state_d = ST_WAIT_IRQ;
        end
      end
      ST_CLR_ST: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_WR_PL;
          phase_d = phase_tgt_s;
        end
      end
      ST_STOP: begin
        state_d = ST_STOP_CLR;
      end
      ST_STOP_CLR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PHASE_FIRST;
      end
    endcase

    // Starting a phase: latch its duration and switch the lights together.
    if (state_d == ST_WR_PL) begin
      dur_lat_d = dur_fix_s;
      lights_d  = lights_for(phase_d);
    end else if (state_d == ST_STOP) begin
      phase_d  = PHASE_FIRST;
      lights_d = LIGHTS_ALL_RED;
    end else begin
      dur_lat_d = dur_lat_q;
    end

    phase_start_d = (state_d == ST_WR_PL);
    busy_d        = (state_d != ST_IDLE);

    // Timer bus cycle for the state being entered, so the bus is registered.
    cs_d    = 1'b1;
    wr_n_d  = 1'b0;
    addr_d  = ADDR_STATUS;
    wdata_d = 16'h0000;
    case (state_d)
      ST_WR_PL: begin
        addr_d  = ADDR_PERIOD_L;
        wdata_d = dur_lat_d[15:0];
      end
      ST_WR_PH: begin
        addr_d  = ADDR_PERIOD_H;
        wdata_d = dur_lat_d[31:16];
      end
      ST_WR_CTRL: begin
        addr_d  = ADDR_CTRL;
        wdata_d = CTRL_START_ITO;
      end
      ST_CLR_ST, ST_STOP_CLR: begin
        addr_d  = ADDR_STATUS;
        wdata_d = STATUS_CLEAR;
      end
      ST_STOP: begin
        addr_d  = ADDR_CTRL;
        wdata_d = CTRL_STOP;
      end
      default: begin
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = ADDR_STATUS;
        wdata_d = 16'h0000;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= PHASE_FIRST;
      dur_lat_q     <= 32'd0;
      lights_q      <= LIGHTS_ALL_RED;
      phase_start_q <= 1'b0;
      busy_q        <= 1'b0;
      cs_q          <= 1'b0;
      wr_n_q        <= 1'b1;
      addr_q        <= ADDR_STATUS;
      wdata_q       <= 16'h0000;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      dur_lat_q     <= dur_lat_d;
      lights_q      <= lights_d;
      phase_start_q <= phase_start_d;
      busy_q        <= busy_d;
      cs_q          <= cs_d;
      wr_n_q        <= wr_n_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wr_n_q;
  assign tmr_writedata  = wdata_q;
  assign phase          = phase_q;
  assign lights         = lights_q;
  assign phase_start    = phase_start_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a timer bus scoreboard.
module tb_traffic_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] dur_0, dur_1, dur_2, dur_3;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic [2:0]  phase;
  logic [5:0]  lights;
  logic        phase_start;
  logic        busy;
`ifdef TPS_PED_REQUEST_EN
  logic        ped_req;
  logic [31:0] dur_walk;
  logic        walk;
`endif

  always #5 clk = ~clk;

  traffic_phase_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .dur_0          (dur_0),
    .dur_1          (dur_1),
    .dur_2          (dur_2),
    .dur_3          (dur_3),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq),
    .phase          (phase),
    .lights         (lights),
    .phase_start    (phase_start),
    .busy           (busy)
`ifdef TPS_PED_REQUEST_EN
    ,
    .ped_req        (ped_req),
    .dur_walk       (dur_walk),
    .walk           (walk)
`endif
  );

  typedef struct packed { logic [2:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [2:0] ph; logic [5:0] lt; } ps_t;

  wr_t wq[$];
  ps_t psq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Simple interval timer: irq rises period+1 clocks after a start write.
  logic        tmr_auto;
  logic        man_irq;
  logic        model_irq;
  logic [15:0] t_pl, t_ph;
  logic [32:0] t_cnt;
  logic        t_run;
  assign tmr_irq = tmr_auto ? model_irq : man_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_pl <= 16'h0; t_ph <= 16'h0; t_cnt <= 33'd0; t_run <= 1'b0; model_irq <= 1'b0;
    end else begin
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata[2]) begin
        t_cnt <= {1'b0, t_ph, t_pl} + 33'd1;
        t_run <= 1'b1;
      end else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata[3]) begin
        t_run <= 1'b0;
      end else if (t_run) begin
        if (t_cnt == 33'd1) begin
          model_irq <= 1'b1;
          t_run     <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 33'd1;
        end
      end
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd2) t_pl <= tmr_writedata;
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd3) t_ph <= tmr_writedata;
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) model_irq <= 1'b0;
    end
  end

  // Bus/phase monitor: pops the scoreboard and checks write spacing.
  int         cyc = 0;
  int         last_cyc = 0;
  logic [2:0] last_addr = 3'd0;
  logic       stop_seen = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_n) begin
      if (tmr_chipselect) begin
        chk("wr_n_low", {31'd0, tmr_write_n}, 32'd0);
        chk("wr_expected", {31'd0, wq.size() > 0}, 32'd1);
        if (wq.size() > 0) begin
          chk("wr_addr", {29'd0, tmr_address}, {29'd0, wq[0].addr});
          chk("wr_data", {16'd0, tmr_writedata}, {16'd0, wq[0].data});
          void'(wq.pop_front());
        end
        if (tmr_address == 3'd3) begin
          chk("pl_ph_gap", cyc - last_cyc, 32'd1);
          chk("pl_ph_order", {29'd0, last_addr}, 32'd2);
        end
        if (tmr_address == 3'd1 && tmr_writedata == 16'h0005) begin
          chk("ph_ctrl_gap", cyc - last_cyc, 32'd1);
          chk("ph_ctrl_order", {29'd0, last_addr}, 32'd3);
        end
        if (tmr_address == 3'd2 && last_addr == 3'd0 && !stop_seen)
          chk("clr_pl_gap", cyc - last_cyc, 32'd2);
        if (tmr_address == 3'd1 && tmr_writedata == 16'h0008) stop_seen <= 1'b1;
        if (tmr_address == 3'd2) stop_seen <= 1'b0;
        last_cyc  <= cyc;
        last_addr <= tmr_address;
      end else begin
        chk("bus_idle", {12'd0, tmr_write_n, tmr_address, tmr_writedata}, 32'h0008_0000);
      end
      if (phase_start) begin
        chk("ps_expected", {31'd0, psq.size() > 0}, 32'd1);
        chk("ps_with_pl", {28'd0, tmr_chipselect, tmr_address}, 32'd10);
        if (psq.size() > 0) begin
          chk("ps_phase", {29'd0, phase}, {29'd0, psq[0].ph});
          chk("ps_lights", {26'd0, lights}, {26'd0, psq[0].lt});
          void'(psq.pop_front());
        end
      end
    end
  end

  task automatic push_phase(input logic with_clr, input logic [15:0] lo, input logic [15:0] hi,
                            input logic [2:0] ph, input logic [5:0] lt);
    if (with_clr) wq.push_back({3'd0, 16'h0000});
    wq.push_back({3'd2, lo});
    wq.push_back({3'd3, hi});
    wq.push_back({3'd1, 16'h0005});
    psq.push_back({ph, lt});
  endtask

  task automatic push_stop();
    wq.push_back({3'd1, 16'h0008});
    wq.push_back({3'd0, 16'h0000});
  endtask

  task automatic drain(input string tag);
    int i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while ((wq.size() != 0 || psq.size() != 0) && i < 400);
    chk({tag, "_drain"}, wq.size() + psq.size(), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
    chk({tag, "_phase"},  {29'd0, phase}, 32'd0);
    chk({tag, "_lights"}, {26'd0, lights}, 32'h24);
    chk({tag, "_cs"},     {31'd0, tmr_chipselect}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; tmr_auto = 1'b0; man_irq = 1'b0;
    dur_0 = 32'd0; dur_1 = 32'd0; dur_2 = 32'd0; dur_3 = 32'd0;
`ifdef TPS_PED_REQUEST_EN
    ped_req = 1'b0; dur_walk = 32'd0;
`endif
    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("rst_wr_n",  {31'd0, tmr_write_n}, 32'd1);
    chk("rst_addr",  {29'd0, tmr_address}, 32'd0);
    chk("rst_wdata", {16'd0, tmr_writedata}, 32'd0);
    chk("rst_ps",    {31'd0, phase_start}, 32'd0);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_rst");

    // First phase start: period halves then control, all on consecutive clocks.
    dur_0 = 32'h0001_0002;
    push_phase(1'b0, 16'h0002, 16'h0001, 3'd0, 6'b001100);
    enable = 1'b1;
    drain("start");
    chk("start_lights", {26'd0, lights}, 32'h0C);
    chk("start_phase",  {29'd0, phase}, 32'd0);
    chk("start_busy",   {31'd0, busy}, 32'd1);
    chk("start_ps_low", {31'd0, phase_start}, 32'd0);
    push_stop();
    enable = 1'b0;
    drain("stop1");
    @(negedge clk); #1;
    chk_idle("stop1");

    // Full cycle with the timer model: 0,1,2,3,0.
    tmr_auto = 1'b1;
    dur_0 = 32'd3; dur_1 = 32'd4; dur_2 = 32'd5; dur_3 = 32'd6;
    push_phase(1'b0, 16'd3, 16'd0, 3'd0, 6'b001100);
    push_phase(1'b1, 16'd4, 16'd0, 3'd1, 6'b010100);
    push_phase(1'b1, 16'd5, 16'd0, 3'd2, 6'b100001);
    push_phase(1'b1, 16'd6, 16'd0, 3'd3, 6'b100010);
    push_phase(1'b1, 16'd3, 16'd0, 3'd0, 6'b001100);
    enable = 1'b1;
    drain("cycle");
    chk("cycle_phase", {29'd0, phase}, 32'd0);

    // Zero duration replaced by the minimum period.
    dur_1 = 32'd0;
    push_phase(1'b1, 16'h0001, 16'h0000, 3'd1, 6'b010100);
    drain("zero_dur");
    push_phase(1'b1, 16'd5, 16'd0, 3'd2, 6'b100001);
    drain("ph2");
    @(negedge clk); #1;
    chk("ph2_phase",  {29'd0, phase}, 32'd2);
    chk("ph2_lights", {26'd0, lights}, 32'h21);
    push_stop();
    enable = 1'b0;
    drain("stop_wait");
    @(negedge clk); #1;
    chk_idle("stop_wait");

    // Disable and timeout in the same cycle: stop path, one status clear.
    tmr_auto = 1'b0;
    dur_0 = 32'd2;
    push_phase(1'b0, 16'd2, 16'd0, 3'd0, 6'b001100);
    enable = 1'b1;
    drain("race_start");
    @(negedge clk); #1;
    push_stop();
    enable = 1'b0;
    man_irq = 1'b1;
    drain("race");
    man_irq = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk_idle("race");

`ifdef TPS_PED_REQUEST_EN
    // Pedestrian request in phase 1 inserts the walk phase after phase 3.
    tmr_auto = 1'b1;
    dur_0 = 32'd2; dur_1 = 32'd2; dur_2 = 32'd2; dur_3 = 32'd2; dur_walk = 32'd10;
    push_phase(1'b0, 16'd2, 16'd0, 3'd0, 6'b001100);
    push_phase(1'b1, 16'd2, 16'd0, 3'd1, 6'b010100);
    enable = 1'b1;
    drain("ped_p1");
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    push_phase(1'b1, 16'd2, 16'd0, 3'd2, 6'b100001);
    push_phase(1'b1, 16'd2, 16'd0, 3'd3, 6'b100010);
    push_phase(1'b1, 16'h000A, 16'd0, 3'd4, 6'b100100);
    drain("ped_walk");
    chk("walk_on",    {31'd0, walk}, 32'd1);
    chk("walk_phase", {29'd0, phase}, 32'd4);
    push_phase(1'b1, 16'd2, 16'd0, 3'd0, 6'b001100);
    drain("ped_back");
    chk("walk_off",   {31'd0, walk}, 32'd0);
    push_stop();
    enable = 1'b0;
    drain("ped_stop");
    @(negedge clk); #1;
    tmr_auto = 1'b0;
`endif

    // Reset in the middle of a write drops chipselect immediately.
    dur_0 = 32'd5;
    push_phase(1'b0, 16'd5, 16'd0, 3'd0, 6'b001100);
    enable = 1'b1;
    for (int i = 0; i < 20 && !tmr_chipselect; i++) @(negedge clk);
    chk("mid_cs_seen", {31'd0, tmr_chipselect}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_cs",     {31'd0, tmr_chipselect}, 32'd0);
    chk("mid_wr_n",   {31'd0, tmr_write_n}, 32'd1);
    chk("mid_ps",     {31'd0, phase_start}, 32'd0);
    chk("mid_busy",   {31'd0, busy}, 32'd0);
    chk("mid_lights", {26'd0, lights}, 32'h24);
    wq.delete();
    psq.delete();
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
